// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for memory-side controllers: the three-phase access
// state encoding and the logic level constants used on enables and pulses.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

endpackage

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter2
// Two-input round-robin grant. Purely combinational; the caller owns the
// last_grant register and updates it when a grant is actually taken.
// Ports:
//   valid0, valid1 : request pending on port 0 / port 1
//   last_grant     : port that won the previous accepted transaction
//   grant_valid    : at least one port is requesting
//   grant          : index of the winning port (meaningful with grant_valid)
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);

    // A lone requester always wins; on a tie the port that did not win
    // last time goes next, so two busy ports alternate.
    always_comb begin
        grant_valid = valid0 | valid1;
        if (valid0 && valid1) begin
            grant = ~last_grant;
        end else begin
            grant = valid1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port memory between two requesters. Each transaction
// goes IDLE -> ACCESS -> RESP, so a response appears two cycles after the
// accepting edge and at most one transaction is in flight.
// Ports:
//   clock, reset                 : clock, asynchronous active-high reset
//   reqN_valid/ready             : request handshake for port N (N = 0,1)
//   reqN_write/addr/wdata        : request fields, held stable until ready
//   respN_valid/rdata/err        : one-cycle completion pulse with read data
//                                  and invalid-address flag
//   mem_write_enabled/read_enabled, mem_address, mem_wdata : to memory
//   mem_rdata (combinational), mem_err (registered)          : from memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int   WORD_SIZE   = 32,
    parameter int   MEMORY_SIZE = 1024,
    parameter logic ON          = mem_arbiter_pkg::ON,
    parameter logic OFF         = mem_arbiter_pkg::OFF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_write,
    input  logic [WORD_SIZE-1:0] req0_addr,
    input  logic [WORD_SIZE-1:0] req0_wdata,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_write,
    input  logic [WORD_SIZE-1:0] req1_addr,
    input  logic [WORD_SIZE-1:0] req1_wdata,
    output logic                 resp0_valid,
    output logic [WORD_SIZE-1:0] resp0_rdata,
    output logic                 resp0_err,
    output logic                 resp1_valid,
    output logic [WORD_SIZE-1:0] resp1_rdata,
    output logic                 resp1_err,
    output logic                 mem_write_enabled,
    output logic                 mem_read_enabled,
    output logic [WORD_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_err
);

    // Address range checking belongs to the memory; the size is kept only
    // so a nonsensical configuration is caught at elaboration.
    if (MEMORY_SIZE < 1) begin : g_memory_size_check
        $error("mem_arbiter: MEMORY_SIZE must be positive");
    end

    arb_state_t           state, state_next;
    logic                 owner_q, write_q, last_grant_q;
    logic [WORD_SIZE-1:0] addr_q, wdata_q;
    logic                 grant_valid, grant, accept;
    logic                 sel_write;
    logic [WORD_SIZE-1:0] sel_addr, sel_wdata;

    rr_arbiter2 u_rr (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // Request fields of whichever port currently wins arbitration.
    always_comb begin
        sel_write = grant ? req1_write : req0_write;
        sel_addr  = grant ? req1_addr  : req0_addr;
        sel_wdata = grant ? req1_wdata : req0_wdata;
    end

    // State register; reset drops back to IDLE immediately, which also
    // kills an in-progress write enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Transaction latch. last_grant resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q      <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            owner_q      <= grant;
            write_q      <= sel_write;
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
            last_grant_q <= grant;
        end
    end

    // Next state and control outputs. Ready is only offered in IDLE and is
    // held off while reset is high even though the state is already IDLE.
    // The write enable lives only in ACCESS so each write sees one edge;
    // reads keep the read enable through RESP where the data is returned.
    always_comb begin
        state_next        = state;
        accept            = OFF;
        req0_ready        = OFF;
        req1_ready        = OFF;
        mem_write_enabled = OFF;
        mem_read_enabled  = OFF;
        resp0_valid       = OFF;
        resp1_valid       = OFF;
        case (state)
            IDLE: begin
                if (grant_valid && !reset) begin
                    accept     = ON;
                    state_next = ACCESS;
                    if (grant) begin
                        req1_ready = ON;
                    end else begin
                        req0_ready = ON;
                    end
                end
            end
            ACCESS: begin
                mem_write_enabled = write_q ? ON : OFF;
                mem_read_enabled  = write_q ? OFF : ON;
                state_next        = RESP;
            end
            RESP: begin
                mem_read_enabled = write_q ? OFF : ON;
                if (owner_q) begin
                    resp1_valid = ON;
                end else begin
                    resp0_valid = ON;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The memory always sees the latched transaction; response data is
    // forced to zero outside the owner's pulse so idle ports stay quiet.
    always_comb begin
        mem_address = addr_q;
        mem_wdata   = wdata_q;
        resp0_rdata = resp0_valid ? mem_rdata : '0;
        resp0_err   = resp0_valid ? mem_err : OFF;
        resp1_rdata = resp1_valid ? mem_rdata : '0;
        resp1_err   = resp1_valid ? mem_err : OFF;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Drives mem_arbiter with directed scenarios and random traffic against a
// simple word memory, and checks every cycle against a transaction-level
// model that tracks how many cycles have passed since the last accept.
module tb_mem_arbiter;

    localparam int W     = 32;
    localparam int MSIZE = 1024;

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   v, w;
    logic [W-1:0] a [2];
    logic [W-1:0] d [2];
    logic         rdy0, rdy1, rv0, rv1, err0, err1;
    logic [W-1:0] rd0, rd1;
    logic         mem_we, mem_re;
    logic [W-1:0] mem_address, mem_wdata, mem_rdata;
    logic         mem_err = 1'b0;
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.WORD_SIZE(W), .MEMORY_SIZE(MSIZE)) dut (
        .clock             (clock),
        .reset             (reset),
        .req0_valid        (v[0]),
        .req0_ready        (rdy0),
        .req0_write        (w[0]),
        .req0_addr         (a[0]),
        .req0_wdata        (d[0]),
        .req1_valid        (v[1]),
        .req1_ready        (rdy1),
        .req1_write        (w[1]),
        .req1_addr         (a[1]),
        .req1_wdata        (d[1]),
        .resp0_valid       (rv0),
        .resp0_rdata       (rd0),
        .resp0_err         (err0),
        .resp1_valid       (rv1),
        .resp1_rdata       (rd1),
        .resp1_err         (err1),
        .mem_write_enabled (mem_we),
        .mem_read_enabled  (mem_re),
        .mem_address       (mem_address),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_err           (mem_err)
    );

    // Memory: combinational read, clocked write, registered address check.
    logic [W-1:0] env_mem [MSIZE] = '{default: '0};

    always @(posedge clock) begin
        if (mem_we && mem_address < MSIZE) env_mem[mem_address[9:0]] <= mem_wdata;
        mem_err <= (mem_address >= MSIZE);
    end

    assign mem_rdata = (mem_address < MSIZE) ? env_mem[mem_address[9:0]] : '0;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a transaction accepted in cycle c occupies memory in
    // cycle c+1 and responds in cycle c+2; any other cycle is free for a new
    // grant, decided by the alternate-on-tie rule.
    logic [W-1:0] mdl [MSIZE] = '{default: '0};

    initial begin : compare
        int           cyc, acc_cyc, off, win;
        logic         last_g, cur_own, cur_w;
        logic [W-1:0] cur_a, cur_d, e_rd;
        logic [1:0]   e_rdy, e_rv;
        logic         e_we, e_re;
        cyc = 0; acc_cyc = -10; last_g = 1'b1;
        cur_own = 1'b0; cur_w = 1'b0; cur_a = '0; cur_d = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                checkOutput("rst_ready", {30'd0, rdy1, rdy0}, 0);
                checkOutput("rst_resp_valid", {30'd0, rv1, rv0}, 0);
                checkOutput("rst_mem_en", {30'd0, mem_we, mem_re}, 0);
                checkOutput("rst_mem_address", mem_address, 0);
                checkOutput("rst_mem_wdata", mem_wdata, 0);
                acc_cyc = cyc - 10; last_g = 1'b1;
                cur_own = 1'b0; cur_w = 1'b0; cur_a = '0; cur_d = '0;
            end else begin
                off = cyc - acc_cyc;
                win = -1;
                if (off >= 3) begin
                    if (v[0] && v[1]) win = last_g ? 0 : 1;
                    else if (v[0]) win = 0;
                    else if (v[1]) win = 1;
                end
                e_rdy = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;
                e_we  = (off == 1) && cur_w;
                e_re  = (off == 1 || off == 2) && !cur_w;
                e_rv  = 2'b00;
                if (off == 2) begin
                    if (cur_w && cur_a < MSIZE) mdl[cur_a[9:0]] = cur_d;
                    e_rv = cur_own ? 2'b10 : 2'b01;
                    e_rd = (cur_a < MSIZE) ? mdl[cur_a[9:0]] : '0;
                    if (cur_own) begin
                        checkOutput("resp1_rdata", rd1, e_rd);
                        checkOutput("resp1_err", {31'd0, err1}, {31'd0, cur_a >= MSIZE});
                    end else begin
                        checkOutput("resp0_rdata", rd0, e_rd);
                        checkOutput("resp0_err", {31'd0, err0}, {31'd0, cur_a >= MSIZE});
                    end
                end
                checkOutput("ready", {30'd0, rdy1, rdy0}, {30'd0, e_rdy});
                checkOutput("resp_valid", {30'd0, rv1, rv0}, {30'd0, e_rv});
                checkOutput("mem_write_enabled", {31'd0, mem_we}, {31'd0, e_we});
                checkOutput("mem_read_enabled", {31'd0, mem_re}, {31'd0, e_re});
                checkOutput("mem_address", mem_address, cur_a);
                checkOutput("mem_wdata", mem_wdata, cur_d);
                if (win >= 0) begin
                    acc_cyc = cyc;
                    cur_own = win[0];
                    cur_w   = w[win];
                    cur_a   = a[win];
                    cur_d   = d[win];
                    last_g  = win[0];
                end
            end
        end
    end

    // Present one request on port p and hold it until it is accepted.
    // Returns just after the accepting edge, i.e. in the ACCESS cycle.
    task automatic applyStimulus(input int p, input logic wr, input logic [W-1:0] addr,
                                 input logic [W-1:0] data);
        bit got;
        got = 1'b0;
        @(posedge clock); #1;
        v[p] = 1'b1; w[p] = wr; a[p] = addr; d[p] = data;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clock);
            if ((p == 0 && rdy0) || (p == 1 && rdy1)) got = 1'b1;
        end
        @(posedge clock); #1;
        v[p] = 1'b0;
        if (!got) checkOutput("accept_timeout", 0, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int         order[$];
        int         exp_order[4];
        logic [1:0] sampled;
        exp_order = '{0, 1, 0, 1};
        reset = 1'b1; v = '0; w = '0;
        a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Write then read back address 5 on port 0.
        applyStimulus(0, 1'b1, 5, 32'hDEADBEEF);
        @(negedge clock) checkOutput("t1_no_resp_in_access", {31'd0, rv0}, 0);
        @(negedge clock) checkOutput("t1_write_resp", {31'd0, rv0}, 1);
        applyStimulus(0, 1'b0, 5, 0);
        @(negedge clock);
        @(negedge clock);
        checkOutput("t1_read_resp", {31'd0, rv0}, 1);
        checkOutput("t1_read_data", rd0, 32'hDEADBEEF);
        checkOutput("t1_read_err", {31'd0, err0}, 0);

        // Continuous ties straight after reset alternate starting with port 0.
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        w = '0; a[0] = 3; a[1] = 4; v = 2'b11;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (rdy0) order.push_back(0);
            if (rdy1) order.push_back(1);
        end
        @(posedge clock); #1 v = '0;
        checkOutput("t2_grant_count", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++)
            checkOutput("t2_grant_order", order[i], exp_order[i]);

        // Out-of-range read on port 1 flags an error.
        applyStimulus(1, 1'b0, 1024, 0);
        @(negedge clock);
        @(negedge clock);
        checkOutput("t3_resp1_valid", {31'd0, rv1}, 1);
        checkOutput("t3_resp1_err", {31'd0, err1}, 1);
        checkOutput("t3_resp0_quiet", {31'd0, rv0}, 0);

        // Port 1 arrives during port 0's transaction and waits for IDLE.
        applyStimulus(0, 1'b1, 9, 32'hCAFE0001);
        v[1] = 1'b1; w[1] = 1'b0; a[1] = 9; d[1] = '0;
        @(negedge clock) checkOutput("t5_wait_access", {31'd0, rdy1}, 0);
        @(negedge clock) checkOutput("t5_wait_resp", {31'd0, rdy1}, 0);
        @(negedge clock) checkOutput("t5_ready_idle", {31'd0, rdy1}, 1);
        @(posedge clock); #1 v[1] = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkOutput("t5_resp1_valid", {31'd0, rv1}, 1);
        checkOutput("t5_resp1_data", rd1, 32'hCAFE0001);

        // Reset during the ACCESS cycle of a write aborts it.
        applyStimulus(0, 1'b1, 7, 32'h12345678);
        checkOutput("t4_we_in_access", {31'd0, mem_we}, 1);
        reset = 1'b1;
        #1 checkOutput("t4_we_dropped", {31'd0, mem_we}, 0);
        repeat (2) begin
            @(negedge clock);
            checkOutput("t4_no_resp", {30'd0, rv1, rv0}, 0);
        end
        @(posedge clock); #1 reset = 1'b0;
        v[1] = 1'b1; w[1] = 1'b0; a[1] = 7;
        @(negedge clock) checkOutput("t4_idle_after_reset", {31'd0, rdy1}, 1);
        @(posedge clock); #1 v[1] = 1'b0;

        // Random traffic on both ports.
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            sampled = {rdy1, rdy0};
            @(posedge clock); #1;
            for (int p = 0; p < 2; p++) begin
                if (v[p] && sampled[p]) v[p] = 1'b0;
                if (!v[p] && $urandom_range(0, 2) == 0) begin
                    v[p] = 1'b1;
                    w[p] = 1'($urandom_range(0, 1));
                    a[p] = ($urandom_range(0, 9) == 0) ? 32'(1024 + $urandom_range(0, 3))
                                                       : 32'($urandom_range(0, 15));
                    d[p] = $urandom;
                end
            end
        end
        v = '0;
        repeat (5) @(posedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
